fifo_read_arbiter: RTL and testbench
====================================

# fifo_read_arbiter

Round-robin arbiter and burst sequencer sharing the read port of the asynchronous FIFO among several consumers in the read-clock domain. It takes burst requests with per-requester lengths and grants one requester at a time. It drives the FIFO read-increment only while the FIFO is not empty, and routes each popped word to the granted consumer with a per-requester valid strobe.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 8: FIFO word width.
- LEN_WIDTH, 4: burst-length field width; maximum burst 2^LEN_WIDTH-1.
- CLK  input  1  read-domain clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  NUM_REQ  per-requester burst request, level; held until DONE for that requester.
- REQ_LEN  input  NUM_REQ*LEN_WIDTH  burst lengths; requester i at bits [i*LEN_WIDTH +: LEN_WIDTH]; sampled at grant.
- EMPTY  input  1  FIFO empty flag, already in the CLK domain.
- RD_DATA  input  DATA_WIDTH  FIFO read data; valid combinationally for the current read address whenever EMPTY=0.
- R_INC  output  1  FIFO read increment (combinational).
- GNT  output  NUM_REQ  one-hot grant, registered.
- OUT_DATA  output  DATA_WIDTH  popped word, registered.
- OUT_VALID  output  NUM_REQ  one-hot strobe marking OUT_DATA for requester i.
- DONE  output  NUM_REQ  one-cycle pulse; the granted burst completed all words.
- BUSY  output  1  high in BURST state.

## Operation
- FSM states: IDLE and BURST. Reset state is IDLE.
- IDLE: if any REQ bit is high, pick the first set bit searching upward from (LAST+1) mod NUM_REQ, wrapping.
  - LAST resets to NUM_REQ-1, so requester 0 wins first.
  - On a pick: GNT gets the one-hot winner, LAST gets the winner, the counter CNT loads REQ_LEN[winner], and the FSM goes to BURST.
  - A length of 0 loads 1.
- BURST: R_INC = REQ[granted] & ~EMPTY.
  - Each cycle with R_INC=1: RD_DATA is captured into OUT_DATA, OUT_VALID[granted] is set next cycle, and CNT decrements.
  - When a read occurs with CNT==1: DONE[granted] pulses next cycle, GNT clears, and the FSM returns to IDLE.
- EMPTY=1 in BURST: R_INC=0. The FSM stalls with GNT held. There is no timeout.
- Abort: REQ[granted] low in BURST means R_INC=0 that cycle. The FSM returns to IDLE next edge, GNT clears, DONE is not pulsed, and LAST stays at the aborted requester.
- R_INC is never high in IDLE and never high while EMPTY=1. This is a hard invariant.
- Requests from non-granted requesters are ignored during BURST. Changes to REQ_LEN after grant are ignored.

## Timing
- Reset values: GNT=0, OUT_DATA=0, OUT_VALID=0, DONE=0, BUSY=0, R_INC=0, CNT=0, LAST=NUM_REQ-1, state=IDLE.
- RST has priority over all other inputs, including mid-burst. Words already popped are lost.
- Request to grant: REQ high at edge k gives GNT/BUSY high after edge k, and the first R_INC is possible in cycle k+1.
- Read to data: R_INC high in cycle n gives OUT_DATA/OUT_VALID in cycle n+1. Latency is 1 and throughput is 1 word per cycle with EMPTY low.
- Last read in cycle n gives DONE and GNT=0 in cycle n+1, and IDLE in n+1. The next grant is at edge n+1, so there is exactly one dead cycle between bursts.
- Back-to-back words: OUT_VALID stays high continuously when EMPTY stays low.
- DONE and the final OUT_VALID are high in the same cycle.

## Structure
- Shared package: FSM state encoding (IDLE=1'b0, BURST=1'b1) and the round-robin helper function.
- Sub-module rr_pick: combinational round-robin priority picker with parameter NUM_REQ.
  - Inputs: REQ and LAST.
  - Outputs: one-hot winner plus its index.
  - It is instantiated once. All state lives in fifo_read_arbiter.
- Width rules:
  - CNT is LEN_WIDTH bits.
  - LAST is $clog2(NUM_REQ) bits.
  - Wrap of (LAST+1) is explicit modulo NUM_REQ, since NUM_REQ may not be a power of 2.

## Test plan
- Single burst: REQ=4'b0001, len 3, FIFO holding A,B,C with EMPTY=0. Required: R_INC high 3 consecutive cycles; OUT_VALID[0] with A,B,C; DONE[0] on the cycle with C; GNT=0 after.
- Round robin: REQ=4'b1111, all len 1, FIFO always non-empty. Required: grants in order 0,1,2,3,0, each separated by one idle cycle; DONE pulses in the same order.
- Empty stall: len 4 granted with 2 words in the FIFO. Required: 2 reads, then R_INC=0 while EMPTY=1 with GNT held; after 2 more words arrive, 2 more reads, then DONE.
- Abort: REQ[2] drops after 1 of 5 words. Required: no further R_INC and no DONE[2]; the next pending requester 3 is granted after IDLE.
- Length 0 and max: len 0 gives exactly 1 read. Len 15 gives 15 reads, with CNT not wrapping.
- Reset mid-burst: RST high for one cycle during BURST. Required next cycle: all outputs 0, state IDLE; requester 0 wins the next arbitration when all requests are high.

Source files
------------

// File: rtl/fifo_read_arbiter_pkg.sv
// Shared definitions for the FIFO read-port arbiter: FSM encoding and the
// round-robin search start helper.
package fifo_read_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // First requester to examine after 'last' won; explicit modulo because
    // the requester count need not be a power of two.
    function automatic int unsigned rr_start(input int unsigned last,
                                             input int unsigned num_req);
        return (last + 1) % num_req;
    endfunction

endpackage

// File: rtl/fifo_read_arbiter_if.sv
// Bundle of request, FIFO read-port and consumer-delivery signals shared
// between the arbiter (master) and its environment (slave).
interface fifo_read_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
);
    // Pop handshake: a FIFO word transfers on every rising CLK edge where
    // R_INC=1; R_INC is only ever asserted while EMPTY=0, and RD_DATA is the
    // word transferred. OUT_VALID/DONE are single-cycle strobes, no back-pressure.
    logic [NUM_REQ-1:0]           REQ;
    logic [NUM_REQ*LEN_WIDTH-1:0] REQ_LEN;
    logic                         EMPTY;
    logic [DATA_WIDTH-1:0]        RD_DATA;
    logic                         R_INC;
    logic [NUM_REQ-1:0]           GNT;
    logic [DATA_WIDTH-1:0]        OUT_DATA;
    logic [NUM_REQ-1:0]           OUT_VALID;
    logic [NUM_REQ-1:0]           DONE;
    logic                         BUSY;

    modport master (
        input  REQ, REQ_LEN, EMPTY, RD_DATA,
        output R_INC, GNT, OUT_DATA, OUT_VALID, DONE, BUSY
    );

    modport slave (
        output REQ, REQ_LEN, EMPTY, RD_DATA,
        input  R_INC, GNT, OUT_DATA, OUT_VALID, DONE, BUSY
    );

endinterface

// File: rtl/fifo_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from (last+1) mod NUM_REQ, returned as one-hot and as an index.
module rr_pick
    import fifo_read_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int LAST_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [LAST_W-1:0]  last,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [LAST_W-1:0]  win_idx,
    output logic               win_valid
);

    int unsigned       start;
    logic [LAST_W-1:0] cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        cand       = '0;
        start      = rr_start(32'(last), NUM_REQ);
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = LAST_W'((start + k) % NUM_REQ);
            if (!win_valid && req[cand]) begin
                win_valid        = 1'b1;
                win_idx          = cand;
                win_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin burst sequencer sharing one FIFO read port among NUM_REQ
// consumers; pops only while the FIFO is non-empty and steers each word.
module fifo_read_arbiter
    import fifo_read_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int LEN_WIDTH  = 4,
    localparam int LAST_W     = $clog2(NUM_REQ)
) (
    input  logic                 CLK,
    input  logic                 RST,
    fifo_read_arbiter_if.master  bus,
    output arb_state_e           dbg_state,
    output logic [LEN_WIDTH-1:0] dbg_cnt,
    output logic [LAST_W-1:0]    dbg_last
);

    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [LAST_W-1:0]     gnt_idx_q, gnt_idx_d;
    logic [LAST_W-1:0]     last_q, last_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [NUM_REQ-1:0]    out_valid_q, out_valid_d;
    logic [NUM_REQ-1:0]    done_q, done_d;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [LAST_W-1:0]     pick_idx;
    logic                  pick_valid;
    logic [LEN_WIDTH-1:0]  pick_len;
    logic                  req_held;
    logic                  rd_en;

    logic [LEN_WIDTH-1:0]  req_len [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
        assign req_len[i] = bus.REQ_LEN[i*LEN_WIDTH +: LEN_WIDTH];
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req        (bus.REQ),
        .last       (last_q),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_valid  (pick_valid)
    );

    // A zero-length request still moves one word.
    assign pick_len = (req_len[pick_idx] == '0) ? LEN_WIDTH'(1) : req_len[pick_idx];
    assign req_held = bus.REQ[gnt_idx_q];
    // RST gating keeps the reset cycle from popping a word nobody will see.
    assign rd_en    = !RST && (state_q == BURST) && req_held && !bus.EMPTY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            last_q      <= LAST_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = '0;
        done_d      = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = BURST;
                    gnt_d     = pick_onehot;
                    gnt_idx_d = pick_idx;
                    last_d    = pick_idx;
                    cnt_d     = pick_len;
                end
            end
            BURST: begin
                if (!req_held) begin
                    // Abort: requester withdrew; LAST keeps pointing at it.
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (rd_en) begin
                    out_data_d  = bus.RD_DATA;
                    out_valid_d = gnt_q;
                    cnt_d       = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        done_d  = gnt_q;
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.R_INC     = rd_en;
    assign bus.GNT       = gnt_q;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.DONE      = done_q;
    assign bus.BUSY      = (state_q == BURST);

    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;
    assign dbg_last  = last_q;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Self-checking bench for fifo_read_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level model and FIFO queue.
module tb_fifo_read_arbiter;
    import fifo_read_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int LW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    arb_state_e    dbg_state;
    logic [LW-1:0] dbg_cnt;
    logic [1:0]    dbg_last;

    fifo_read_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    fifo_read_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_cnt   (dbg_cnt),
        .dbg_last  (dbg_last)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            gnt_order[$];
    logic [NR-1:0] prev_gnt;
    int            rd_cnt;
    bit            sticky, auto_fill, rand_mode;

    // Reference model: who owns the port, words left, last winner.
    int            m_busy, m_owner, m_rem, m_last;
    logic [NR-1:0] e_gnt, e_out_valid, e_done;
    logic [DW-1:0] e_out_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_rem = 0; m_last = NR - 1;
        e_gnt = '0; e_out_valid = '0; e_done = '0; e_out_data = '0;
        exp_q.delete();
    endtask

    function automatic int len_of(input int c);
        return int'(bus.REQ_LEN[c*LW +: LW]);
    endfunction

    task automatic model_cycle(input bit rd);
        int c;
        e_out_valid = '0;
        e_done      = '0;
        if (RST) begin
            model_reset();
            return;
        end
        if (m_busy == 0) begin
            for (int k = 1; k <= NR; k++) begin
                c = (m_last + k) % NR;
                if (bus.REQ[c]) begin
                    m_busy = 1; m_owner = c; m_last = c;
                    m_rem  = (len_of(c) == 0) ? 1 : len_of(c);
                    e_gnt = '0; e_gnt[c] = 1'b1;
                    break;
                end
            end
        end else if (!bus.REQ[m_owner]) begin
            m_busy = 0;
            e_gnt  = '0;
        end else if (rd) begin
            exp_q.push_back(fifo_q[0]);
            e_out_data = fifo_q[0];
            e_out_valid[m_owner] = 1'b1;
            m_rem--;
            if (m_rem == 0) begin
                e_done[m_owner] = 1'b1;
                e_gnt  = '0;
                m_busy = 0;
            end
        end
    endtask

    task automatic set_len(input int i, input int l);
        bus.REQ_LEN[i*LW +: LW] = LW'(l);
    endtask

    task automatic apply_fifo();
        if (auto_fill) while (fifo_q.size() < 6) fifo_q.push_back(DW'($urandom));
        bus.EMPTY   = (fifo_q.size() == 0);
        bus.RD_DATA = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
    endtask

    task automatic step();
        bit exp_rinc, did_rd;
        @(negedge CLK);
        exp_rinc = !RST && (m_busy != 0) && bus.REQ[m_owner] && (fifo_q.size() != 0);
        did_rd   = bus.R_INC;
        check("r_inc", 32'(bus.R_INC), 32'(exp_rinc));
        if (did_rd) rd_cnt++;
        model_cycle(exp_rinc);
        @(posedge CLK);
        #1;
        check("gnt",       32'(bus.GNT),       32'(e_gnt));
        check("out_valid", 32'(bus.OUT_VALID), 32'(e_out_valid));
        check("out_data",  32'(bus.OUT_DATA),  32'(e_out_data));
        check("done",      32'(bus.DONE),      32'(e_done));
        check("busy",      32'(bus.BUSY),      32'(m_busy));
        check("state",     32'(dbg_state),     32'(m_busy));
        check("cnt",       32'(dbg_cnt),       32'(m_rem));
        check("last",      32'(dbg_last),      32'(m_last));
        if (bus.OUT_VALID != '0) begin
            if (exp_q.size() == 0) check("sb_extra", 32'(bus.OUT_VALID), 32'(0));
            else                   check("sb_data", 32'(bus.OUT_DATA), 32'(exp_q.pop_front()));
        end
        if (did_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (prev_gnt == '0 && bus.GNT != '0)
            for (int i = 0; i < NR; i++) if (bus.GNT[i]) gnt_order.push_back(i);
        prev_gnt = bus.GNT;
        if (!sticky)
            for (int i = 0; i < NR; i++) if (bus.DONE[i]) bus.REQ[i] = 1'b0;
        if (rand_mode) begin
            for (int i = 0; i < NR; i++) begin
                if (!bus.REQ[i] && $urandom_range(0, 3) == 0) begin
                    bus.REQ[i] = 1'b1;
                    set_len(i, int'($urandom_range(0, 15)));
                end else if (bus.REQ[i] && m_busy != 0 && m_owner == i && $urandom_range(0, 24) == 0) begin
                    bus.REQ[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    set_len(i, int'($urandom_range(0, 15)));
                end
            end
            if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16) fifo_q.push_back(DW'($urandom));
        end
        apply_fifo();
    endtask

    task automatic do_reset();
        bus.REQ = '0;
        fifo_q.delete();
        RST = 1'b1;
        apply_fifo();
        step();
        step();
        RST = 1'b0;
    endtask

    int exp_rr[5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.REQ = '0; bus.REQ_LEN = '0;
        sticky = 0; auto_fill = 0; rand_mode = 0;
        prev_gnt = '0; rd_cnt = 0;
        model_reset();

        // Reset values.
        do_reset();

        // Single burst of A,B,C to requester 0.
        fifo_q = '{8'hA1, 8'hB2, 8'hC3};
        set_len(0, 3);
        bus.REQ = 4'b0001;
        apply_fifo();
        rd_cnt = 0;
        repeat (7) step();
        check("single_reads", 32'(rd_cnt), 32'(3));

        // Round robin with all requesters held, length 1.
        do_reset();
        auto_fill = 1; sticky = 1;
        for (int i = 0; i < NR; i++) set_len(i, 1);
        bus.REQ = 4'b1111;
        apply_fifo();
        gnt_order.delete();
        repeat (17) step();
        check("rr_count", 32'(gnt_order.size() >= 5), 32'(1));
        for (int k = 0; k < 5; k++)
            if (k < gnt_order.size()) check("rr_order", 32'(gnt_order[k]), 32'(exp_rr[k]));
        sticky = 0;
        bus.REQ = '0;
        repeat (3) step();

        // Empty stall: length 4 with only 2 words available.
        auto_fill = 0;
        do_reset();
        fifo_q = '{8'h11, 8'h22};
        set_len(1, 4);
        bus.REQ = 4'b0010;
        apply_fifo();
        rd_cnt = 0;
        repeat (8) step();
        check("stall_reads", 32'(rd_cnt), 32'(2));
        check("stall_gnt", 32'(bus.GNT), 32'(4'b0010));
        fifo_q.push_back(8'h33);
        fifo_q.push_back(8'h44);
        apply_fifo();
        repeat (6) step();
        check("stall_total", 32'(rd_cnt), 32'(4));

        // Abort: requester 2 withdraws after one word, 3 is next.
        do_reset();
        auto_fill = 1;
        set_len(2, 5); set_len(3, 2);
        bus.REQ = 4'b0100;
        apply_fifo();
        rd_cnt = 0;
        step();
        bus.REQ[3] = 1'b1;
        step();
        bus.REQ[2] = 1'b0;
        step();
        step();
        check("abort_next_gnt", 32'(bus.GNT), 32'(4'b1000));
        check("abort_reads", 32'(rd_cnt), 32'(1));
        repeat (5) step();

        // Length 0 moves one word; length 15 moves fifteen.
        do_reset();
        set_len(0, 0);
        bus.REQ = 4'b0001;
        rd_cnt = 0;
        repeat (5) step();
        check("len0_reads", 32'(rd_cnt), 32'(1));
        set_len(0, 15);
        bus.REQ = 4'b0001;
        rd_cnt = 0;
        repeat (20) step();
        check("len15_reads", 32'(rd_cnt), 32'(15));

        // Reset in the middle of a burst.
        set_len(1, 5);
        bus.REQ = 4'b0010;
        repeat (3) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        bus.REQ = 4'b1111;
        for (int i = 0; i < NR; i++) set_len(i, 2);
        step();
        check("post_reset_gnt", 32'(bus.GNT), 32'(4'b0001));
        bus.REQ = '0;
        repeat (3) step();

        // Randomized traffic with aborts, length changes and FIFO underflow.
        auto_fill = 0; rand_mode = 1;
        repeat (500) step();
        rand_mode = 0;
        bus.REQ = '0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
